// File: rtl/pipe_stage_skid.sv
// Pipeline stage with one skid entry: a main register that drives the outputs
// and a skid register that takes the entry arriving while downstream stalls.
module pipe_stage_skid #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  FLUSH,
  input  logic                  VALID_IN,
  output logic                  READY_OUT,
  input  logic [CTRL_WIDTH-1:0] CTRL_IN,
  input  logic [WIDTH-1:0]      DATA_A_IN,
  input  logic [WIDTH-1:0]      DATA_B_IN,
  output logic                  VALID_OUT,
  input  logic                  READY_IN,
  output logic [CTRL_WIDTH-1:0] CTRL_OUT,
  output logic [WIDTH-1:0]      DATA_A_OUT,
  output logic [WIDTH-1:0]      DATA_B_OUT,
  output logic [CNT_WIDTH-1:0]  STALL_CNT
);

  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t                state, state_nxt;
  logic                  accept, emit;
  logic                  load_main_in, load_main_skid, load_skid;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
  logic [WIDTH-1:0]      main_a, main_b, skid_a, skid_b;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept = VALID_IN && READY_OUT;
  assign emit   = VALID_OUT && READY_IN;

  always_ff @(posedge CLK) begin
    if (CLR) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Load enables are derived alongside the transitions so a flush suppresses both.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (FLUSH) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt    = BUSY;
          load_main_in = 1'b1;
        end
        BUSY: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (emit) begin
          state_nxt      = BUSY;
          load_main_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    READY_OUT = (state != FULL);
    VALID_OUT = (state == BUSY) || (state == FULL);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      main_ctrl <= '0;
      main_a    <= '0;
      main_b    <= '0;
      skid_ctrl <= '0;
      skid_a    <= '0;
      skid_b    <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= CTRL_IN;
        main_a    <= DATA_A_IN;
        main_b    <= DATA_B_IN;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_a    <= skid_a;
        main_b    <= skid_b;
      end
      if (load_skid) begin
        skid_ctrl <= CTRL_IN;
        skid_a    <= DATA_A_IN;
        skid_b    <= DATA_B_IN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR)                                   stall_cnt <= '0;
    else if (!FLUSH && VALID_OUT && !READY_IN) stall_cnt <= sat_inc(stall_cnt);
  end

  assign CTRL_OUT   = main_ctrl;
  assign DATA_A_OUT = main_a;
  assign DATA_B_OUT = main_b;
  assign STALL_CNT  = stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, all checked
// against a two-entry FIFO reference model with a saturating stall counter.
module tb_pipe_stage_skid;
  localparam int W  = 32;
  localparam int CW = 3;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          CLK = 1'b0;
  logic          CLR, FLUSH, VALID_IN, READY_IN;
  logic          READY_OUT, VALID_OUT;
  logic [CW-1:0] CTRL_IN, CTRL_OUT;
  logic [W-1:0]  DATA_A_IN, DATA_B_IN, DATA_A_OUT, DATA_B_OUT;
  logic [NW-1:0] STALL_CNT;

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.WIDTH(W), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .CLK(CLK), .CLR(CLR), .FLUSH(FLUSH), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
    .CTRL_IN(CTRL_IN), .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
    .VALID_OUT(VALID_OUT), .READY_IN(READY_IN), .CTRL_OUT(CTRL_OUT),
    .DATA_A_OUT(DATA_A_OUT), .DATA_B_OUT(DATA_B_OUT), .STALL_CNT(STALL_CNT)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   cnt_m;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic r, input logic [W-1:0] a);
    VALID_IN  = v;
    READY_IN  = r;
    DATA_A_IN = a;
    DATA_B_IN = $urandom;
    CTRL_IN   = CW'($urandom);
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic tick();
    int   sz;
    bit   acc, emt;
    ent_t ein;
    sz  = q.size();
    acc = VALID_IN && (sz < 2);
    emt = (sz > 0) && READY_IN;
    ein = {CTRL_IN, DATA_A_IN, DATA_B_IN};
    @(posedge CLK);
    if (CLR) begin
      q.delete();
      last  = '0;
      cnt_m = 0;
    end else if (FLUSH) begin
      q.delete();
    end else begin
      if (sz > 0 && !READY_IN && cnt_m < CNT_MAX) cnt_m++;
      if (emt) void'(q.pop_front());
      if (acc) q.push_back(ein);
    end
    if (q.size() > 0) last = q[0];
    #1;
    chk("valid_out", 64'(VALID_OUT), 64'(q.size() > 0));
    chk("ready_out", 64'(READY_OUT), 64'(q.size() < 2));
    chk("ctrl_out",  64'(CTRL_OUT),  64'(last.c));
    chk("data_a",    64'(DATA_A_OUT), 64'(last.a));
    chk("data_b",    64'(DATA_B_OUT), 64'(last.b));
    chk("stall_cnt", 64'(STALL_CNT), 64'(cnt_m));
  endtask

  initial begin
    CLR = 1'b1;
    FLUSH = 1'b0;
    drive(1'b0, 1'b0, '0);
    last = '0;
    cnt_m = 0;
    tick();
    tick();
    chk("reset_ready", 64'(READY_OUT), 64'd1);
    chk("reset_a", 64'(DATA_A_OUT), 64'd0);
    CLR = 1'b0;

    // Streaming at full rate
    drive(1'b1, 1'b1, 32'h11); tick(); chk("stream_11", 64'(DATA_A_OUT), 64'h11);
    drive(1'b1, 1'b1, 32'h22); tick(); chk("stream_22", 64'(DATA_A_OUT), 64'h22);
    drive(1'b1, 1'b1, 32'h33); tick(); chk("stream_33", 64'(DATA_A_OUT), 64'h33);
    chk("stream_cnt", 64'(STALL_CNT), 64'd0);
    drive(1'b0, 1'b1, '0); tick(); chk("drain_hold", 64'(DATA_A_OUT), 64'h33);

    // Back-pressure into the skid register
    drive(1'b1, 1'b0, 32'hA); tick();
    drive(1'b1, 1'b0, 32'hB); tick();
    chk("full_ready", 64'(READY_OUT), 64'd0);
    chk("full_head", 64'(DATA_A_OUT), 64'hA);
    drive(1'b0, 1'b1, '0); tick(); chk("skid_out_b", 64'(DATA_A_OUT), 64'hB);
    tick();
    chk("skid_empty", 64'(VALID_OUT), 64'd0);
    chk("skid_cnt", 64'(STALL_CNT), 64'd1);

    // Flush from FULL with a competing accept
    drive(1'b1, 1'b0, 32'hD); tick();
    drive(1'b1, 1'b0, 32'hE); tick();
    FLUSH = 1'b1;
    drive(1'b1, 1'b0, 32'hC); tick();
    FLUSH = 1'b0;
    chk("flush_valid", 64'(VALID_OUT), 64'd0);
    chk("flush_hold", 64'(DATA_A_OUT), 64'hD);
    chk("flush_cnt", 64'(STALL_CNT), 64'd2);
    drive(1'b0, 1'b1, '0); tick(); tick();
    chk("flush_no_c", 64'(DATA_A_OUT), 64'hD);

    // Counter saturation
    drive(1'b1, 1'b0, 32'hF); tick();
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_sat", 64'(STALL_CNT), 64'(CNT_MAX));

    // Clear in FULL with flush and valid asserted
    CLR = 1'b1; tick(); CLR = 1'b0;
    drive(1'b1, 1'b0, 32'h5A); tick();
    drive(1'b1, 1'b0, 32'h5B); tick();
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_clr_cnt", 64'(STALL_CNT), 64'd5);
    CLR = 1'b1; FLUSH = 1'b1;
    drive(1'b1, 1'b0, 32'h77); tick();
    CLR = 1'b0; FLUSH = 1'b0;
    chk("clr_cnt", 64'(STALL_CNT), 64'd0);
    chk("clr_a", 64'(DATA_A_OUT), 64'd0);
    chk("clr_ready", 64'(READY_OUT), 64'd1);

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      FLUSH = ($urandom_range(0, 49) == 0);
      drive(1'($urandom), 1'($urandom), $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the width of each data channel.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 3, giving the width of the control bundle (e.g. regwrite, memtoreg, memwrite).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the stall counter.

Interface
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  clock; all state updates on the rising edge.
REQ-006 CLR  in  1  synchronous active-high reset.
REQ-007 FLUSH  in  1  synchronous pipeline flush; discards all held entries.
REQ-008 VALID_IN  in  1  upstream entry present.
REQ-009 READY_OUT  out  1  stage can accept an entry this cycle.
REQ-010 CTRL_IN  in  CTRL_WIDTH  upstream control bundle.
REQ-011 DATA_A_IN  in  WIDTH  upstream data channel A (ALU result).
REQ-012 DATA_B_IN  in  WIDTH  upstream data channel B (store data).
REQ-013 VALID_OUT  out  1  downstream entry present.
REQ-014 READY_IN  in  1  downstream can accept.
REQ-015 CTRL_OUT  out  CTRL_WIDTH, DATA_A_OUT  out  WIDTH, DATA_B_OUT  out  WIDTH: head entry.
REQ-016 STALL_CNT  out  CNT_WIDTH  count of back-pressured cycles.

Function
REQ-017 Accept event = VALID_IN && READY_OUT; emit event = VALID_OUT && READY_IN.
REQ-018 Storage SHALL be a main register (drives outputs) plus one skid register; entries leave in arrival order.
REQ-019 FSM states: EMPTY (no entries), BUSY (main full, skid empty), FULL (both full).
REQ-020 READY_OUT SHALL be 1 in EMPTY and BUSY and 0 in FULL, decoded from state only (no combinational path from READY_IN).
REQ-021 VALID_OUT SHALL be 1 in BUSY and FULL, 0 in EMPTY.
REQ-022 EMPTY: accept -> BUSY, main <= inputs; else stay.
REQ-023 BUSY: accept and emit -> BUSY, main <= inputs; accept without emit -> FULL, skid <= inputs; emit without accept -> EMPTY; neither -> stay.
REQ-024 FULL: emit -> BUSY, main <= skid; no emit -> stay; VALID_IN ignored.
REQ-025 Latency SHALL be 1 cycle from accept in EMPTY to VALID_OUT; sustained throughput 1 entry/cycle when READY_IN=1.
REQ-026 Data/control outputs SHALL hold their last value when VALID_OUT=0 and whenever no load occurs.
REQ-027 FLUSH=1 SHALL force next state EMPTY, discard any same-cycle accept, leave data registers unchanged, and not alter STALL_CNT.
REQ-028 STALL_CNT SHALL increment by 1 each cycle VALID_OUT && !READY_IN, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-029 Priority SHALL be CLR > FLUSH > normal operation.

Reset
REQ-030 CLR=1 at a rising edge SHALL set state EMPTY, READY_OUT=1, VALID_OUT=0, main and skid registers (CTRL_OUT, DATA_A_OUT, DATA_B_OUT) to 0, STALL_CNT to 0.
REQ-031 CLR asserted mid-operation (BUSY or FULL) SHALL discard all entries with the same result as REQ-030, regardless of FLUSH, VALID_IN, READY_IN.
REQ-032 First accept SHALL be possible on the first rising edge after CLR deasserts.

Verification
REQ-033 CLR 2 cycles, then VALID_IN=1, READY_IN=1, DATA_A_IN=0x11,0x22,0x33 on consecutive cycles -> DATA_A_OUT 0x11,0x22,0x33 one cycle later each, VALID_OUT=1 continuously, READY_OUT=1, STALL_CNT=0.
REQ-034 In BUSY holding A=0xA, READY_IN=0, offer A=0xB -> FULL, READY_OUT=0; next cycle READY_IN=1 -> 0xA emitted, then 0xB; no loss, no duplicate; STALL_CNT=1.
REQ-035 In FULL, drive FLUSH=1 with VALID_IN=1, A=0xC -> next cycle EMPTY, VALID_OUT=0, READY_OUT=1, 0xC never emitted, outputs hold last values.
REQ-036 CNT_WIDTH=4, hold VALID_OUT=1, READY_IN=0 for 20 cycles -> STALL_CNT reaches 15 and stays 15.
REQ-037 In FULL with STALL_CNT=5, assert CLR together with FLUSH and VALID_IN -> next cycle all outputs 0, READY_OUT=1, VALID_OUT=0, STALL_CNT=0.
REQ-038 Random VALID_IN/READY_IN for 1000 cycles with random 32-bit data -> output sequence equals accepted sequence (scoreboard), READY_OUT=0 only in FULL.
